// File: rtl/handshake_constant_seq_if.sv
// -----------------------------------------------------------------------------
// handshake_constant_seq_if
//
// Purpose: bundles the two valid/ready channels of handshake_constant_seq.
//   - control channel (payload-less): ctrl_valid / ctrl_ready
//   - data channel:                   outs / outs_valid / outs_ready
//                                     (+ outs_last when HANDSHAKE_CONSTANT_SEQ_LAST_EN)
//
// Modports:
//   master : the constant source. It drives ctrl_ready, outs, outs_valid and
//            outs_last, and receives ctrl_valid and outs_ready.
//   slave  : the surrounding circuit. It is the mirror image of master.
//
// Optional feature macro: HANDSHAKE_CONSTANT_SEQ_LAST_EN adds outs_last.
// -----------------------------------------------------------------------------
interface handshake_constant_seq_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  logic                  outs_last;
`endif

  modport master (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_valid,
    input  outs_ready
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    ,
    output outs_last
`endif
  );

  modport slave (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    output outs_ready
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    ,
    input  outs_last
`endif
  );
endinterface

// File: rtl/handshake_constant_seq.sv
// -----------------------------------------------------------------------------
// handshake_constant_seq
//
// Purpose: elastic constant source. Every accepted control token emits the
// next entry of a packed constant table (cyclic, DEPTH entries) through a
// one-slot output register, so ctrl_valid never reaches outs/outs_valid
// combinationally. Typical use: per-iteration polynomial coefficients.
//
// Parameters:
//   DATA_WIDTH : width of each constant and of outs.
//   DEPTH      : number of table entries (>= 1, any value, not only 2^n).
//   VALUES     : packed table, entry i at [i*DATA_WIDTH +: DATA_WIDTH].
//
// Ports:
//   clk  : clock, rising edge.
//   rst  : synchronous active-high reset.
//   bus  : handshake_constant_seq_if.master
//            ctrl_valid  in  control token present (no payload)
//            ctrl_ready  out token accepted this cycle (= !outs_valid || outs_ready)
//            outs        out current constant
//            outs_valid  out outs holds a token
//            outs_ready  in  consumer takes the token
//            outs_last   out (HANDSHAKE_CONSTANT_SEQ_LAST_EN only) token is the
//                            final table entry of a pass
//
// Optional feature macro: HANDSHAKE_CONSTANT_SEQ_LAST_EN.
// -----------------------------------------------------------------------------
module handshake_constant_seq #(
  parameter int                          DATA_WIDTH = 24,
  parameter int                          DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] VALUES     = '0
) (
  input logic                     clk,
  input logic                     rst,
  handshake_constant_seq_if.master bus
);

  // One pointer bit minimum so DEPTH = 1 still has a legal vector.
  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]      ptr;
  logic [DATA_WIDTH-1:0] outs_q;
  logic                  outs_valid_q;
  logic [DATA_WIDTH-1:0] entry;
  logic                  at_last;
  logic                  accept;

  // The slot may be refilled whenever it is empty or is being drained in the
  // same cycle; this depends on outs_ready only, never on ctrl_valid.
  assign bus.ctrl_ready = !outs_valid_q || bus.outs_ready;
  assign accept         = bus.ctrl_valid && bus.ctrl_ready;
  assign at_last        = (ptr == PTR_LAST);

  // Table read as an explicit mux over the valid entries: pointer values at
  // or above DEPTH are unreachable, so they simply fall through to zero.
  always_comb begin
    // NOTE: default assignment first, so no path through the loop leaves
    // entry unassigned and no latch is inferred.
    entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr == PTR_W'(i)) begin
        entry = VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: outs is cleared too (not just outs_valid) because a defined
      // zero is observable on the bus after reset.
      ptr          <= '0;
      outs_q       <= '0;
      outs_valid_q <= 1'b0;
    end else if (accept) begin
      // Covers both the empty-slot fill and the same-cycle drain + refill.
      outs_q       <= entry;
      outs_valid_q <= 1'b1;
      ptr          <= at_last ? '0 : ptr + PTR_W'(1);
    end else if (bus.outs_ready) begin
      // Drain only: outs keeps its last value, just the valid flag drops.
      outs_valid_q <= 1'b0;
    end
  end

  assign bus.outs       = outs_q;
  assign bus.outs_valid = outs_valid_q;

`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  // End-of-pass marker travels with the data word, loaded on the same accept.
  logic outs_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      outs_last_q <= 1'b0;
    end else if (accept) begin
      outs_last_q <= at_last;
    end
  end

  assign bus.outs_last = outs_last_q;
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// -----------------------------------------------------------------------------
// tb_handshake_constant_seq
//
// Two instances share one stimulus: dut3 (DEPTH=3, FD652C/0029AD/7FFFFF) and
// dut1 (DEPTH=1, 00ABCD). A token-level model (pending-token count, accept
// index modulo DEPTH) checks every cycle; directed scenarios add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_handshake_constant_seq;

  logic clk = 1'b0;
  logic rst;
  logic cv;
  logic ordy;

  always #5 clk = ~clk;

  handshake_constant_seq_if #(.DATA_WIDTH(24)) bus3 ();
  handshake_constant_seq_if #(.DATA_WIDTH(24)) bus1 ();

  assign bus3.ctrl_valid = cv;
  assign bus3.outs_ready = ordy;
  assign bus1.ctrl_valid = cv;
  assign bus1.outs_ready = ordy;

  handshake_constant_seq #(
    .DATA_WIDTH (24),
    .DEPTH      (3),
    .VALUES     ({24'h7FFFFF, 24'h0029AD, 24'hFD652C})
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  handshake_constant_seq #(
    .DATA_WIDTH (24),
    .DEPTH      (1),
    .VALUES     (24'h00ABCD)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic l3, l1;
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  assign l3 = bus3.outs_last;
  assign l1 = bus1.outs_last;
`else
  assign l3 = 1'b0;
  assign l1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Token-level model. Index 0 = dut3, 1 = dut1.
  // ---------------------------------------------------------------------------
  logic [23:0] tbl3 [3] = '{24'hFD652C, 24'h0029AD, 24'h7FFFFF};
  bit          live = 1'b0;
  int          pend       [2] = '{0, 0};
  int          n_acc      [2] = '{0, 0};
  logic [23:0] m_out      [2] = '{24'h0, 24'h0};
  logic        m_last     [2] = '{1'b0, 1'b0};
  int          dut_acc    [2] = '{0, 0};
  int          dut_out_hs [2] = '{0, 0};

  task automatic model_step(input int d, input logic crdy, input logic ovld,
                            input logic [23:0] o, input logic ol);
    int   depth;
    int   idx;
    logic acc;
    depth = (d == 0) ? 3 : 1;
    if (live) begin
      check($sformatf("dut%0d ctrl_ready", depth), 32'(crdy), 32'((pend[d] == 0) || ordy));
      check($sformatf("dut%0d outs_valid", depth), 32'(ovld), 32'(pend[d] != 0));
      check($sformatf("dut%0d outs", depth), 32'(o), 32'(m_out[d]));
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
      check($sformatf("dut%0d outs_last", depth), 32'(ol), 32'(m_last[d]));
`endif
      if (!rst) begin
        if (ovld && ordy) dut_out_hs[d]++;
        if (cv && crdy)   dut_acc[d]++;
      end
    end
    if (rst) begin
      pend[d] = 0; n_acc[d] = 0; m_out[d] = '0; m_last[d] = 1'b0;
      dut_acc[d] = 0; dut_out_hs[d] = 0;
    end else begin
      acc = cv && ((pend[d] == 0) || ordy);
      if (pend[d] > 0 && ordy) pend[d]--;
      if (acc) begin
        idx       = n_acc[d] % depth;
        pend[d]++;
        m_out[d]  = (d == 0) ? tbl3[idx] : 24'h00ABCD;
        m_last[d] = (idx == depth - 1);
        n_acc[d]++;
      end
    end
  endtask

  // Inputs change at posedge+1, so at negedge they equal what the next
  // posedge will sample.
  always @(negedge clk) begin
    model_step(0, bus3.ctrl_ready, bus3.outs_valid, bus3.outs, l3);
    model_step(1, bus1.ctrl_ready, bus1.outs_valid, bus1.outs, l1);
    if (rst) live = 1'b1;
  end

  // One cycle: drive at posedge+1, return at the following negedge.
  task automatic cyc(input logic r, input logic v, input logic o);
    @(posedge clk);
    #1;
    rst = r; cv = v; ordy = o;
    @(negedge clk);
  endtask

  logic [23:0] seq1 [7] = '{24'hFD652C, 24'h0029AD, 24'h7FFFFF, 24'hFD652C,
                            24'h0029AD, 24'h7FFFFF, 24'hFD652C};
  logic        lst1 [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1; cv = 1'b0; ordy = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    // Reset state
    check("rst outs_valid", 32'(bus3.outs_valid), 32'h0);
    check("rst outs", 32'(bus3.outs), 32'h0);
    check("rst ctrl_ready", 32'(bus3.ctrl_ready), 32'h1);
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    check("rst outs_last", 32'(l3), 32'h0);
`endif

    // Scenario 1: 7 back-to-back accepts, full throughput
    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 1);
      if (i > 0) begin
        check($sformatf("s1 outs[%0d]", i - 1), 32'(bus3.outs), 32'(seq1[i - 1]));
        check($sformatf("s1 dut1 outs[%0d]", i - 1), 32'(bus1.outs), 32'h00ABCD);
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
        check($sformatf("s1 last[%0d]", i - 1), 32'(l3), 32'(lst1[i - 1]));
        check($sformatf("s1 dut1 last[%0d]", i - 1), 32'(l1), 32'h1);
`endif
      end
    end
    cyc(0, 0, 1);
    check("s1 outs[6]", 32'(bus3.outs), 32'(seq1[6]));
    check("s1 valid[6]", 32'(bus3.outs_valid), 32'h1);

    // Scenario 2: stall after one token
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0);
      check("s2 stall outs", 32'(bus3.outs), 32'hFD652C);
      check("s2 stall valid", 32'(bus3.outs_valid), 32'h1);
      check("s2 stall ctrl_ready", 32'(bus3.ctrl_ready), 32'h0);
    end
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    check("s2 release outs", 32'(bus3.outs), 32'h0029AD);
    check("s2 release valid", 32'(bus3.outs_valid), 32'h1);

    // Scenario 4: reset in the middle of a stall holding 0029AD
    cyc(1, 1, 0);
    check("s4 pre-reset outs", 32'(bus3.outs), 32'h0029AD);
    cyc(0, 0, 0);
    check("s4 reset valid", 32'(bus3.outs_valid), 32'h0);
    check("s4 reset outs", 32'(bus3.outs), 32'h0);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    check("s4 first outs", 32'(bus3.outs), 32'hFD652C);
    check("s4 first valid", 32'(bus3.outs_valid), 32'h1);

    // Scenario 3: random traffic, model checks every cycle
    for (int i = 0; i < 1000; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("s3 dut3 accepts==emits", 32'(dut_acc[0]), 32'(dut_out_hs[0]));
    check("s3 dut1 accepts==emits", 32'(dut_acc[1]), 32'(dut_out_hs[1]));
    check("s3 drained", 32'(bus3.outs_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
